// File: rtl/pc_call_stack.sv
// pc_call_stack: next-address source for the program counter.
// Resolves JMP / CALL / RET requests combinationally so the PC can be
// redirected with zero added latency, and keeps a LIFO of return addresses
// (PC_COUNT+1) that is pushed on CALL and popped on RET. Rejected requests
// (overflow, underflow, more than one request at once) leave the stack alone,
// suppress the load and set a sticky error flag.
module pc_call_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [AW-1:0] PC_COUNT,
  input  logic [AW-1:0] TARGET,
  input  logic          JMP,
  input  logic          CALL,
  input  logic          RET,
  input  logic          ERR_CLR,
  output logic [AW-1:0] DIN,
  output logic          LD,
  output logic          STK_EMPTY,
  output logic          STK_FULL,
  output logic [CW-1:0] STK_CNT,
  output logic          STK_ERR
);

  // Pointer width into the storage array; DEPTH is a power of two.
  localparam int PW = $clog2(DEPTH);

  // Decoded request kinds.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_JMP   = 3'd1,
    OP_PUSH  = 3'd2,
    OP_POP   = 3'd3,
    OP_ERROR = 3'd4
  } op_e;

  logic [AW-1:0] mem_r [DEPTH];
  logic [CW-1:0] cnt_r;
  logic          err_r;

  logic [1:0]    req_num_s;
  logic          full_s;
  logic          empty_s;
  logic [PW-1:0] wr_idx_s;
  logic [PW-1:0] top_idx_s;
  logic [AW-1:0] pc_inc_s;
  op_e           op_s;

  assign full_s    = (cnt_r == CW'(DEPTH));
  assign empty_s   = (cnt_r == CW'(0));
  // On a full stack wr_idx_s aliases entry 0, but pushes are blocked then.
  assign wr_idx_s  = PW'(cnt_r);
  assign top_idx_s = PW'(cnt_r - CW'(1));
  // Return address wraps at AW bits (all-ones + 1 -> 0).
  assign pc_inc_s  = PC_COUNT + AW'(1);
  assign req_num_s = 2'(JMP) + 2'(CALL) + 2'(RET);

  // Classify this cycle's request from the request lines and the stack level.
  always_comb begin
    op_s = OP_NONE;
    if (req_num_s > 2'd1) begin
      op_s = OP_ERROR;
    end else if (JMP) begin
      op_s = OP_JMP;
    end else if (CALL) begin
      op_s = full_s ? OP_ERROR : OP_PUSH;
    end else if (RET) begin
      op_s = empty_s ? OP_ERROR : OP_POP;
    end else begin
      op_s = OP_NONE;
    end
  end

  // Drive the PC load enable and next address for the decoded request.
  always_comb begin
    DIN = pc_inc_s;
    LD  = 1'b0;
    case (op_s)
      OP_JMP: begin
        DIN = TARGET;
        LD  = 1'b1;
      end
      OP_PUSH: begin
        DIN = TARGET;
        LD  = 1'b1;
      end
      OP_POP: begin
        DIN = mem_r[top_idx_s];
        LD  = 1'b1;
      end
      default: begin
        DIN = pc_inc_s;
        LD  = 1'b0;
      end
    endcase
  end

  // Stack storage and occupancy; popped entries are left in place.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= AW'(0);
      end
    end else begin
      case (op_s)
        OP_PUSH: begin
          mem_r[wr_idx_s] <= pc_inc_s;
          cnt_r           <= cnt_r + CW'(1);
        end
        OP_POP: begin
          cnt_r <= cnt_r - CW'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Sticky error flag; a new error in the clearing cycle keeps it set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_r <= 1'b0;
    end else if (op_s == OP_ERROR) begin
      err_r <= 1'b1;
    end else if (ERR_CLR) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign STK_CNT   = cnt_r;
  assign STK_FULL  = full_s;
  assign STK_EMPTY = empty_s;
  assign STK_ERR   = err_r;

endmodule

// File: tb/tb_pc_call_stack.sv
// tb_pc_call_stack: directed scoreboard bench for pc_call_stack.
// Each stimulus step pushes the hand-computed response into a queue; the
// monitor pops one entry every falling edge and compares LD/DIN (for the
// request applied this cycle) and the status outputs (stack state going
// into this cycle's rising edge).
module tb_pc_call_stack;

  localparam int AW = 10;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] pc_count;
  logic [AW-1:0] target;
  logic          jmp;
  logic          call;
  logic          ret;
  logic          err_clr;
  logic [AW-1:0] din;
  logic          ld;
  logic          stk_empty;
  logic          stk_full;
  logic [CW-1:0] stk_cnt;
  logic          stk_err;

  pc_call_stack #(.AW(AW), .DEPTH(8)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .PC_COUNT (pc_count),
    .TARGET   (target),
    .JMP      (jmp),
    .CALL     (call),
    .RET      (ret),
    .ERR_CLR  (err_clr),
    .DIN      (din),
    .LD       (ld),
    .STK_EMPTY(stk_empty),
    .STK_FULL (stk_full),
    .STK_CNT  (stk_cnt),
    .STK_ERR  (stk_err)
  );

  typedef struct {
    string         nm;
    logic          ld;
    logic [AW-1:0] din;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, f, act, req);
    end
  endtask

  // Monitor: pop and compare one expectation per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "LD",        int'(ld),        int'(e.ld));
        chk(e.nm, "DIN",       int'(din),       int'(e.din));
        chk(e.nm, "STK_CNT",   int'(stk_cnt),   int'(e.cnt));
        chk(e.nm, "STK_ERR",   int'(stk_err),   int'(e.err));
        chk(e.nm, "STK_FULL",  int'(stk_full),  (e.cnt == 4'd8) ? 1 : 0);
        chk(e.nm, "STK_EMPTY", int'(stk_empty), (e.cnt == 4'd0) ? 1 : 0);
      end
    end
  end

  // Apply one request shortly after a rising edge and queue its expectation.
  task automatic step(input string nm, input logic rst, input logic j, input logic c,
                      input logic r, input logic clr, input logic [AW-1:0] pc,
                      input logic [AW-1:0] tgt, input logic e_ld, input logic [AW-1:0] e_din,
                      input logic [CW-1:0] e_cnt, input logic e_err);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n    = rst;
    jmp      = j;
    call     = c;
    ret      = r;
    err_clr  = clr;
    pc_count = pc;
    target   = tgt;
    e.nm  = nm;
    e.ld  = e_ld;
    e.din = e_din;
    e.cnt = e_cnt;
    e.err = e_err;
    q.push_back(e);
  endtask

  initial begin
    rst_n    = 1'b0;
    jmp      = 1'b0;
    call     = 1'b0;
    ret      = 1'b0;
    err_clr  = 1'b0;
    pc_count = 10'h000;
    target   = 10'h000;
    repeat (2) @(posedge clk);

    //    name        rst   J     C     R     CLR   PC       TGT      LD    DIN      CNT   ERR
    step("reset",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 10'h001, 4'd0, 1'b0);
    step("call1",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h045, 10'h200, 1'b1, 10'h200, 4'd0, 1'b0);
    step("ret1",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h200, 10'h000, 1'b1, 10'h046, 4'd1, 1'b0);
    step("idle1",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h046, 10'h000, 1'b0, 10'h047, 4'd0, 1'b0);
    step("jmp",       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h046, 10'h123, 1'b1, 10'h123, 4'd0, 1'b0);

    // Fill the stack with eight CALLs from 0x010..0x017.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h010 + 10'(i), 10'h300,
           1'b1, 10'h300, 4'(i), 1'b0);
    end
    step("ovf",       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h018, 10'h300, 1'b0, 10'h019, 4'd8, 1'b0);
    // Drain: return addresses come back 0x018 down to 0x011.
    for (int i = 0; i < 8; i++) begin
      step($sformatf("drain%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h300, 10'h000,
           1'b1, 10'h018 - 10'(i), 4'(8 - i), 1'b1);
    end
    step("idle2",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h050, 10'h000, 1'b0, 10'h051, 4'd0, 1'b1);
    step("clr1",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h050, 10'h000, 1'b0, 10'h051, 4'd0, 1'b1);

    // Return-address wrap at the top of the address space.
    step("wcall",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h100, 1'b1, 10'h100, 4'd0, 1'b0);
    step("wret",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 10'h000, 1'b1, 10'h000, 4'd1, 1'b0);
    step("idle3",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 10'h001, 4'd0, 1'b0);

    // Underflow, then a clear that coincides with a fresh underflow.
    step("unf",       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h010, 10'h000, 1'b0, 10'h011, 4'd0, 1'b0);
    step("unf_clr",   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h010, 10'h000, 1'b0, 10'h011, 4'd0, 1'b1);
    step("clr2",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010, 10'h000, 1'b0, 10'h011, 4'd0, 1'b1);
    step("idle4",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h010, 10'h000, 1'b0, 10'h011, 4'd0, 1'b0);

    // Illegal JMP+CALL with one entry on the stack.
    step("icall",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h020, 10'h100, 1'b1, 10'h100, 4'd0, 1'b0);
    step("illegal",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h100, 10'h200, 1'b0, 10'h101, 4'd1, 1'b0);
    step("clr3",      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h100, 10'h000, 1'b0, 10'h101, 4'd1, 1'b1);
    step("iret",      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h101, 10'h000, 1'b1, 10'h021, 4'd1, 1'b0);
    step("idle5",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h021, 10'h000, 1'b0, 10'h022, 4'd0, 1'b0);

    // Asynchronous reset between edges after three CALLs.
    step("acall0",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h030, 10'h100, 1'b1, 10'h100, 4'd0, 1'b0);
    step("acall1",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h031, 10'h100, 1'b1, 10'h100, 4'd1, 1'b0);
    step("acall2",    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h032, 10'h100, 1'b1, 10'h100, 4'd2, 1'b0);
    step("arst",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h100, 10'h000, 1'b0, 10'h101, 4'd0, 1'b0);
    step("arel_ret",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 10'h000, 1'b0, 10'h101, 4'd0, 1'b0);
    step("idle6",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h100, 10'h000, 1'b0, 10'h101, 4'd0, 1'b1);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    chk("drain", "queue_left", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
